pong_renderer: RTL

Frame renderer downstream of the game-logic block. It reads the 8-byte object table (paddles and ball) from the shared object RAM's read port, snapshots it, and streams one 128x64 monochrome frame as 1024 page-ordered bytes to the display driver. Streaming uses a valid/ready handshake, with one frame per request.

---
 rtl/pong_pkg.sv | 59 +++++
 rtl/pong_renderer_if.sv | 13 +
 rtl/pong_column_byte.sv | 49 ++++
 rtl/pong_renderer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared constants, object-table layout and render state encoding
// for the pong renderer and its neighbours (game logic, display driver).
package pong_pkg;

  // Screen geometry: 128 columns by 64 rows, stored as 8 pages of 8 rows.
  localparam int SCREEN_W    = 128;
  localparam int SCREEN_H    = 64;
  localparam int PAGES       = SCREEN_H / 8;
  localparam int FRAME_BYTES = SCREEN_W * PAGES;

  // Object geometry in pixels.
  localparam int PADDLE_W  = 2;
  localparam int BALL_SIZE = 2;

  // Object RAM layout.
  localparam int OBJ_BYTES = 8;
  localparam logic [4:0] ADDR_P1_X   = 5'd0;
  localparam logic [4:0] ADDR_P1_Y   = 5'd1;
  localparam logic [4:0] ADDR_P1_H   = 5'd2;
  localparam logic [4:0] ADDR_P2_X   = 5'd3;
  localparam logic [4:0] ADDR_P2_Y   = 5'd4;
  localparam logic [4:0] ADDR_P2_H   = 5'd5;
  localparam logic [4:0] ADDR_BALL_X = 5'd6;
  localparam logic [4:0] ADDR_BALL_Y = 5'd7;

  // Key codes shared with the game-logic block.
  localparam logic [7:0] KEY_NONE    = 8'h00;
  localparam logic [7:0] KEY_P1_UP   = 8'h01;
  localparam logic [7:0] KEY_P1_DOWN = 8'h02;
  localparam logic [7:0] KEY_P2_UP   = 8'h04;
  localparam logic [7:0] KEY_P2_DOWN = 8'h08;

  // Render controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } render_state_t;

  // Snapshot of the object table, field order matches the RAM map.
  typedef struct packed {
    logic [7:0] p1_x;
    logic [7:0] p1_y;
    logic [7:0] p1_h;
    logic [7:0] p2_x;
    logic [7:0] p2_y;
    logic [7:0] p2_h;
    logic [7:0] ball_x;
    logic [7:0] ball_y;
  } obj_table_t;

  // True when v lies in [lo, lo+len-1]; all arithmetic is 9 bits so lo+len
  // never wraps, and len=0 yields an empty span.
  function automatic logic span_hit(input logic [8:0] v, input logic [7:0] lo,
                                    input logic [8:0] len);
    return ({1'b0, lo} <= v) && (v < ({1'b0, lo} + len));
  endfunction

endpackage

// File: rtl/pong_renderer_if.sv
// pong_renderer_if: byte stream from the renderer to the display driver.
// Handshake: a byte moves on a rising edge where o_valid && i_ready; while
// o_valid is high and i_ready low, o_data/o_last hold, and o_valid only
// drops after a transfer.
interface pong_renderer_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_last;

  modport master (output o_data, output o_valid, output o_last, input i_ready);
  modport slave  (input o_data, input o_valid, input o_last, output i_ready);
endinterface

// File: rtl/pong_column_byte.sv
// pong_column_byte: combinational pixel generator for one 8-row column slice.
// Bit k of o_byte is pixel (i_col, i_page*8+k). Optional macro
// PONG_RENDER_BORDER_EN lights row 3 across the whole screen.
module pong_column_byte
  import pong_pkg::*;
(
  input  obj_table_t i_snap,
  input  logic [6:0] i_col,
  input  logic [2:0] i_page,
  output logic [7:0] o_byte
);

  logic [8:0] w_col;
  logic       w_p1_col;
  logic       w_p2_col;
  logic       w_ball_col;
  logic [7:0] w_p1_rows;
  logic [7:0] w_p2_rows;
  logic [7:0] w_ball_rows;
  logic [7:0] w_objects;

  assign w_col      = {2'b00, i_col};
  assign w_p1_col   = span_hit(w_col, i_snap.p1_x,   9'(PADDLE_W));
  assign w_p2_col   = span_hit(w_col, i_snap.p2_x,   9'(PADDLE_W));
  assign w_ball_col = span_hit(w_col, i_snap.ball_x, 9'(BALL_SIZE));

  // One row comparator per rectangle for each of the 8 rows in the page.
  for (genvar k = 0; k < 8; k++) begin : g_row
    logic [8:0] w_row;
    assign w_row          = {3'b000, i_page, 3'(k)};
    assign w_p1_rows[k]   = span_hit(w_row, i_snap.p1_y,   {1'b0, i_snap.p1_h});
    assign w_p2_rows[k]   = span_hit(w_row, i_snap.p2_y,   {1'b0, i_snap.p2_h});
    assign w_ball_rows[k] = span_hit(w_row, i_snap.ball_y, 9'(BALL_SIZE));
  end

  assign w_objects = ({8{w_p1_col}}   & w_p1_rows)
                   | ({8{w_p2_col}}   & w_p2_rows)
                   | ({8{w_ball_col}} & w_ball_rows);

`ifdef PONG_RENDER_BORDER_EN
  // Score-area separator: row 3 sits in page 0, bit 3.
  logic [7:0] w_border;
  assign w_border = (i_page == 3'd0) ? 8'h08 : 8'h00;
  assign o_byte   = w_objects | w_border;
`else
  assign o_byte = w_objects;
`endif

endmodule

// File: rtl/pong_renderer.sv
// pong_renderer: fetches the 8-byte object table into a frozen snapshot,
// then streams one 128x64 frame as 1024 page-ordered bytes per request.
// Optional macro PONG_RENDER_BORDER_EN (handled in pong_column_byte) adds
// a lit separator on row 3.
module pong_renderer
  import pong_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_frame_req,
  output logic [4:0]      o_ram_address,
  input  logic [7:0]      i_ram_data,
  output logic            o_busy,
  pong_renderer_if.master stream,
  output render_state_t   o_dbg_state
);

  render_state_t r_state;
  render_state_t w_state_next;

  // r_cnt counts edges spent in FETCH: address r_cnt is driven while
  // r_cnt<=7 and the byte for address r_cnt-1 is captured while 1<=r_cnt<=8.
  logic [3:0] r_cnt;
  logic [7:0] r_snap [0:7];
  logic [9:0] r_idx;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_last;

  logic       w_capture;
  logic       w_load;
  logic       w_advance;
  logic       w_finish;
  logic [2:0] w_slot;
  logic [9:0] w_next_idx;
  logic [7:0] w_byte;
  obj_table_t w_snap;

  assign w_snap = '{p1_x:   r_snap[0], p1_y:   r_snap[1], p1_h: r_snap[2],
                    p2_x:   r_snap[3], p2_y:   r_snap[4], p2_h: r_snap[5],
                    ball_x: r_snap[6], ball_y: r_snap[7]};

  assign w_slot     = 3'(r_cnt - 4'd1);
  assign w_next_idx = w_load ? 10'd0 : (r_idx + 10'd1);

  pong_column_byte u_column_byte (
    .i_snap (w_snap),
    .i_col  (w_next_idx[6:0]),
    .i_page (w_next_idx[9:7]),
    .o_byte (w_byte)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_frame_req) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_capture = (r_cnt >= 4'd1) && (r_cnt <= 4'd8);
        if (r_cnt == 4'd9) begin
          w_load       = 1'b1;
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (r_valid && stream.i_ready) begin
          if (r_last) begin
            w_finish     = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Fetch sequencer: counts only while fetching, parked at 0 otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_cnt <= 4'd0;
    else if (r_state == ST_FETCH) r_cnt <= r_cnt + 4'd1;
    else                        r_cnt <= 4'd0;
  end

  // Snapshot capture; untouched during STREAM so the frame cannot tear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < OBJ_BYTES; i++) r_snap[i] <= 8'h00;
    end else if (w_capture) begin
      r_snap[w_slot] <= i_ram_data;
    end
  end

  // Output byte register: loads byte 0 after the fetch, the next byte after
  // each transfer, and holds otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx   <= 10'd0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load || w_advance) begin
      r_idx   <= w_next_idx;
      r_data  <= w_byte;
      r_valid <= 1'b1;
      r_last  <= (w_next_idx == 10'(FRAME_BYTES - 1));
    end else if (w_finish) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_ram_address = ((r_state == ST_FETCH) && (r_cnt <= 4'd7)) ? {2'b00, r_cnt[2:0]} : 5'd0;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_dbg_state   = r_state;
  assign stream.o_data  = r_data;
  assign stream.o_valid = r_valid;
  assign stream.o_last  = r_last;

endmodule
